// File: rtl/led_col_scanner.sv
// led_col_scanner: self-timed active-low column scan with dwell, strobe and frame pulses (optional blanking via LED_COL_SCAN_BLANK_EN)
module led_col_scanner #(
  parameter int NUM_COLS = 5,
  parameter int DWELL = 1000,
  parameter int BLANK = 1,
  localparam int IDX_W = (NUM_COLS > 2) ? $clog2(NUM_COLS) : 1,
  localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  output logic [NUM_COLS-1:0] col_n,
  output logic [IDX_W-1:0]    col_idx,
  output logic                col_strobe,
  output logic                frame_done
);
`ifdef LED_COL_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int BL = BLANK_EN ? BLANK : 0;
  logic [CNT_W-1:0] dwell_cnt;
  logic blank, cnt_last, col_last;
  // blanking window, end-of-column and last-column decode of the pre-edge state
  always_comb begin
    blank = int'(dwell_cnt) < BL;
    cnt_last = dwell_cnt == CNT_W'(DWELL - 1);
    col_last = col_idx == IDX_W'(NUM_COLS - 1);
  end
  // scan state and registered column drive, strobe and frame pulses
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      dwell_cnt <= '0;
      col_idx <= '0;
      col_n <= '1;
      col_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else if (en) begin
      col_n <= blank ? '1 : ~(NUM_COLS'(1) << col_idx);
      col_strobe <= dwell_cnt == '0;
      frame_done <= cnt_last && col_last;
      dwell_cnt <= cnt_last ? '0 : dwell_cnt + CNT_W'(1);
      col_idx <= !cnt_last ? col_idx : col_last ? '0 : col_idx + IDX_W'(1);
    end else begin
      col_n <= '1;
      col_strobe <= 1'b0;
      frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_col_scanner.sv
// tb_led_col_scanner: directed scoreboard bench for led_col_scanner (NUM_COLS=5, DWELL=4, BLANK=1)
module tb_led_col_scanner;
  typedef struct packed {
    logic [4:0] n;
    logic [2:0] i;
    logic       st;
    logic       fd;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en, sync;
  logic [4:0] col_n;
  logic [2:0] col_idx;
  logic col_strobe, frame_done;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pc = 0;
  int pk = 0;
  led_col_scanner #(.NUM_COLS(5), .DWELL(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .col_n(col_n), .col_idx(col_idx), .col_strobe(col_strobe), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, got, want);
    end
  endtask
  function automatic logic [4:0] pat(input int c, input int k);
    logic [4:0] one;
`ifdef LED_COL_SCAN_BLANK_EN
    if (k < 1) return 5'b11111;
`endif
    one = 5'b00001;
    return ~(one << c);
  endfunction
  task automatic tick(input logic r, s, e, input logic [4:0] n, input logic [2:0] i, input logic st, fd);
    exp_t x;
    rst = r;
    sync = s;
    en = e;
    sb.push_back('{n, i, st, fd});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("col_n", 8'(col_n), 8'(x.n));
    chk("col_idx", 8'(col_idx), 8'(x.i));
    chk("col_strobe", 8'(col_strobe), 8'(x.st));
    chk("frame_done", 8'(frame_done), 8'(x.fd));
  endtask
  task automatic scan(input int cnt);
    logic [4:0] p;
    logic st, fd;
    for (int j = 0; j < cnt; j++) begin
      p = pat(pc, pk);
      st = pk == 0;
      fd = pc == 4 && pk == 3;
      pk++;
      if (pk == 4) begin
        pk = 0;
        pc = (pc + 1) % 5;
      end
      tick(1'b0, 1'b0, 1'b1, p, 3'(pc), st, fd);
    end
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    sync = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 5'b11111, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 5'b11111, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 5'b11111, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 5'b11111, 3'd0, 1'b0, 1'b0);
    scan(28);
    scan(2);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 5'b11111, 3'd2, 1'b0, 1'b0);
    scan(3);
    tick(1'b0, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0);
    pc = 0;
    pk = 0;
    scan(4);
    scan(14);
    tick(1'b1, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0);
    pc = 0;
    pk = 0;
    scan(6);
    tick(1'b0, 1'b0, 1'b0, 5'b11111, 3'd1, 1'b0, 1'b0);
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_col_scanner.md
# led_col_scanner

Time-multiplexed column scanner for the LED matrix display. It steps an active-low one-hot column enable through `NUM_COLS` columns, holding each column for `DWELL` clock cycles. It also reports the current column index so the row-pattern logic can fetch that column's data, and emits per-column and per-frame pulses. It sits between the system clock domain and the column drivers and replaces fixed 3-bit column decoding with a self-timed, parametrised scan.

## Interface
- `NUM_COLS`, default 5: number of matrix columns; legal range 2..16.
- `DWELL`, default 1000: clock cycles each column is held; must be ≥ 2.
- `BLANK`, default 1: leading cycles of each column interval during which all columns are off. Only used with `LED_COL_SCAN_BLANK_EN`; must satisfy 1 ≤ `BLANK` < `DWELL`.
- Derived widths: `IDX_W` = max(1, clog2(`NUM_COLS`)); `CNT_W` = max(1, clog2(`DWELL`)).
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `en` in 1: scan enable; when low, the scan freezes and the display is dark.
- `sync` in 1: frame restart; returns the scan to column 0.
- `col_n` out `NUM_COLS`: active-low one-hot column enable; bit i low means column i is driven.
- `col_idx` out `IDX_W`: current scan column, 0..`NUM_COLS`-1.
- `col_strobe` out 1: one-cycle pulse marking the first cycle of each column interval.
- `frame_done` out 1: one-cycle pulse marking the final cycle of the last column.

## Operation
- Internal state is `dwell_cnt` (`CNT_W` bits) and `col_idx`. The outputs `col_n`, `col_strobe` and `frame_done` are registered; no output is combinational.
- Priority at each edge: `rst` > `sync` > `en`.
- `rst`: sets `dwell_cnt`=0, `col_idx`=0, `col_n`=all ones, `col_strobe`=0, `frame_done`=0.
- `sync`=1, regardless of `en`:
  - `dwell_cnt`←0 and `col_idx`←0.
  - `col_n`←all ones; `col_strobe`←0; `frame_done`←0.
  - The next enabled cycle starts a full column-0 interval.
- `en`=1, `sync`=0:
  - Outputs are computed from the state present before the edge:
    - `col_n`←~onehot(`col_idx`), or all ones if blanked;
    - `col_strobe`←(`dwell_cnt`==0);
    - `frame_done`←(`dwell_cnt`==`DWELL`-1 && `col_idx`==`NUM_COLS`-1).
  - State update: `dwell_cnt`←`dwell_cnt`+1. At `DWELL`-1, `dwell_cnt` instead wraps to 0 and `col_idx` advances. `col_idx` wraps from `NUM_COLS`-1 to 0.
- `en`=0, `sync`=0: `dwell_cnt` and `col_idx` hold; `col_n`←all ones; `col_strobe`←0; `frame_done`←0.
- Re-enabling resumes the interrupted column. It shows only the remaining `DWELL`-`dwell_cnt` cycles, and `col_strobe` is not re-issued for it.
- No more than one bit of `col_n` is ever low. Unused `col_idx` codes (≥ `NUM_COLS`) are unreachable.

## Timing
- Pipeline: `col_n`, `col_strobe` and `frame_done` lag `col_idx` by one cycle. Row logic uses `col_idx` to prefetch the pattern so that it aligns with `col_n`.
- After `rst` release with `en`=1: `col_n` is all ones for the first cycle. Column 0 is then active for exactly `DWELL` cycles, and each later column also for exactly `DWELL` cycles.
- Frame period is `NUM_COLS`×`DWELL` cycles. `frame_done` pulses once per frame and `col_strobe` pulses `NUM_COLS` times per frame.
- `sync` costs one dark cycle (the edge it is sampled on), after which column 0 starts.
- `rst` mid-frame: full reset on that edge; any pending pulse is suppressed.

## Configuration
- `LED_COL_SCAN_BLANK_EN` defined: ghosting suppression is enabled. `col_n` is forced to all ones while the sampled `dwell_cnt` < `BLANK`. Each column is therefore lit for `DWELL`-`BLANK` cycles, and `col_strobe` coincides with the first blank cycle. `col_idx` and `frame_done` timing are unchanged.
- Not defined: the `BLANK` parameter is ignored and each column is lit for all `DWELL` cycles.

## Test plan
All scenarios use `NUM_COLS`=5, `DWELL`=4, `BLANK`=1.
- Reset with `en`=0: `col_n`=5'b11111, `col_idx`=0, `col_strobe`=0, `frame_done`=0, held until `en` rises.
- Free-run with `en`=1 from reset:
  - `col_n` reads 11110×4, 11101×4, 11011×4, 10111×4, 01111×4, then 11110 again.
  - `col_strobe` pulses every 4 cycles.
  - `frame_done` pulses once, on the last 01111 cycle (20-cycle period).
- Drop `en` for 3 cycles after 2 cycles of column 2: `col_n`=11111 for 3 cycles, then 11011 for 2 cycles with no `col_strobe`, then 10111.
- Assert `sync` mid-column 3: next cycle `col_n`=11111, then 11110 for 4 cycles with `col_strobe` on the first of them; no `frame_done`.
- With `LED_COL_SCAN_BLANK_EN` defined, free-run: each column shows 11111 for 1 cycle then its one-hot pattern for 3 cycles; `col_strobe` lands on the blank cycle.
- Same-edge `rst`=1, `sync`=1, `en`=1 during column 4: the reset state is observed and `frame_done` never pulses for that frame.
